// File: rtl/stage_wb_pkg.sv
// ============================================================================
// Module      : stage_wb_pkg
// Description : Shared pipeline decode constants and the MEM/WB record type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package stage_wb_pkg;

   // Load-size encodings carried in funct3
   localparam logic [2:0] c_f3_lb  = 3'b000;
   localparam logic [2:0] c_f3_lh  = 3'b001;
   localparam logic [2:0] c_f3_lw  = 3'b010;
   localparam logic [2:0] c_f3_lbu = 3'b100;
   localparam logic [2:0] c_f3_lhu = 3'b101;

   typedef struct packed {
      logic        valid;
      logic [31:0] alu_o;
      logic [31:0] mem_data;
      logic        mem_read;
      logic        reg_write;
      logic [4:0]  rd;
      logic [2:0]  funct3;
   } memwb_t;

endpackage

`default_nettype wire

// File: rtl/stage_wb_load_align.sv
// ============================================================================
// Module      : load_align
// Description : Byte/halfword lane selection, extension and misalign detect.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_align
   import stage_wb_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  addr,
   input  logic [2:0]  funct3,
   output logic [31:0] data,
   output logic        misalign
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = word[7:0];
      case (addr)
         2'd0:    w_byte = word[7:0];
         2'd1:    w_byte = word[15:8];
         2'd2:    w_byte = word[23:16];
         default: w_byte = word[31:24];
      endcase
      w_half = addr[1] ? word[31:16] : word[15:0];
   end

   always_comb begin
      data = word;
      case (funct3)
         c_f3_lb:  data = {{24{w_byte[7]}}, w_byte};
         c_f3_lh:  data = {{16{w_half[15]}}, w_half};
         c_f3_lw:  data = word;
         c_f3_lbu: data = {24'd0, w_byte};
         c_f3_lhu: data = {16'd0, w_half};
         default:  data = word;
      endcase
   end

   assign misalign = (((funct3 == c_f3_lh) || (funct3 == c_f3_lhu)) && addr[0])
                   || ((funct3 == c_f3_lw) && (addr != 2'd0));

endmodule

`default_nettype wire

// File: rtl/stage_wb.sv
// ============================================================================
// Module      : stage_wb
// Description : MEM/WB pipeline register, load extraction and retire counter.
//               Define WB_INSTRET_EN to build the retired-instruction counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stage_wb
   import stage_wb_pkg::*;
#(
   parameter int INSTRET_W = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 me_valid,
   input  logic [31:0]          me_alu_o,
   input  logic [31:0]          me_mem_data,
   input  logic                 me_mem_read,
   input  logic                 me_reg_write,
   input  logic [4:0]           me_rd,
   input  logic [2:0]           me_funct3,
   input  logic                 stall,
   input  logic                 flush,
   output logic [31:0]          w_regs_data,
   output logic                 w_reg_write,
   output logic [4:0]           w_rd,
   output logic                 w_valid,
   output logic                 w_load_misalign,
   output logic [INSTRET_W-1:0] instret
);

   memwb_t      r_q;
   memwb_t      w_d;
   logic [31:0] w_load_data;
   logic        w_misalign_raw;

   assign w_d = '{valid:     me_valid,
                  alu_o:     me_alu_o,
                  mem_data:  me_mem_data,
                  mem_read:  me_mem_read,
                  reg_write: me_reg_write,
                  rd:        me_rd,
                  funct3:    me_funct3};

   // Flush only kills the slot; the payload fields are left as they were.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_q <= '0;
      end else if (flush) begin
         r_q.valid     <= 1'b0;
         r_q.reg_write <= 1'b0;
      end else if (!stall) begin
         r_q <= w_d;
      end
   end

   load_align u_load_align (
      .word     (r_q.mem_data),
      .addr     (r_q.alu_o[1:0]),
      .funct3   (r_q.funct3),
      .data     (w_load_data),
      .misalign (w_misalign_raw)
   );

   assign w_load_misalign = r_q.valid & r_q.mem_read & w_misalign_raw;
   assign w_regs_data     = r_q.mem_read ? w_load_data : r_q.alu_o;
   assign w_reg_write     = r_q.valid & r_q.reg_write & (r_q.rd != 5'd0) & ~w_load_misalign;
   assign w_valid         = r_q.valid;
   assign w_rd            = r_q.rd;

`ifdef WB_INSTRET_EN
   logic [INSTRET_W-1:0] r_instret;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_instret <= '0;
      end else if (!flush && !stall && me_valid) begin
         r_instret <= r_instret + {{(INSTRET_W-1){1'b0}}, 1'b1};
      end
   end

   assign instret = r_instret;
`else
   assign instret = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_stage_wb.sv
// ============================================================================
// Module      : tb_stage_wb
// Description : Randomized and directed checks of stage_wb against a model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stage_wb;

   logic        clk = 1'b0;
   logic        rst;
   logic        me_valid, me_mem_read, me_reg_write, stall, flush;
   logic [31:0] me_alu_o, me_mem_data;
   logic [4:0]  me_rd;
   logic [2:0]  me_funct3;
   logic [31:0] w_regs_data;
   logic        w_reg_write, w_valid, w_load_misalign;
   logic [4:0]  w_rd;
   logic [3:0]  instret;

   int n_checks = 0;
   int n_errors = 0;

   // Reference state: what the writeback slot should hold
   logic        m_valid, m_mem_read, m_reg_write;
   logic [31:0] m_alu, m_mem;
   logic [4:0]  m_rd;
   logic [2:0]  m_f3;
   int          m_retired;

   stage_wb #(.INSTRET_W(4)) dut (
      .clk(clk), .rst(rst),
      .me_valid(me_valid), .me_alu_o(me_alu_o), .me_mem_data(me_mem_data),
      .me_mem_read(me_mem_read), .me_reg_write(me_reg_write), .me_rd(me_rd),
      .me_funct3(me_funct3), .stall(stall), .flush(flush),
      .w_regs_data(w_regs_data), .w_reg_write(w_reg_write), .w_rd(w_rd),
      .w_valid(w_valid), .w_load_misalign(w_load_misalign), .instret(instret)
   );

   always #5 clk = ~clk;

   task automatic chk_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_data();
      logic [31:0] b, h;
      if (!m_mem_read) return m_alu;
      b = (m_mem >> (8 * m_alu[1:0])) & 32'hFF;
      h = (m_mem >> (16 * m_alu[1])) & 32'hFFFF;
      case (m_f3)
         3'd0:    return (b >= 128)   ? b + 32'hFFFF_FF00 : b;
         3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
         3'd4:    return b;
         3'd5:    return h;
         default: return m_mem;
      endcase
   endfunction

   function automatic logic ref_misalign();
      if (!(m_valid && m_mem_read)) return 1'b0;
      if ((m_f3 == 3'd1 || m_f3 == 3'd5) && (m_alu % 2 != 0)) return 1'b1;
      if (m_f3 == 3'd2 && (m_alu % 4 != 0)) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_edge();
      if (!rst) begin
         {m_valid, m_mem_read, m_reg_write, m_alu, m_mem, m_rd, m_f3} = '0;
         m_retired = 0;
      end else if (flush) begin
         m_valid = 1'b0;
         m_reg_write = 1'b0;
      end else if (!stall) begin
         m_valid = me_valid; m_alu = me_alu_o; m_mem = me_mem_data;
         m_mem_read = me_mem_read; m_reg_write = me_reg_write;
         m_rd = me_rd; m_f3 = me_funct3;
         if (me_valid) m_retired++;
      end
   endtask

   task automatic tick();
      logic exp_mis;
      @(posedge clk);
      model_edge();
      #1;
      exp_mis = ref_misalign();
      chk_value("regs_data", w_regs_data, ref_data());
      chk_value("misalign", w_load_misalign, exp_mis);
      chk_value("reg_write", w_reg_write, m_valid && m_reg_write && m_rd != 0 && !exp_mis);
      chk_value("rd", w_rd, m_rd);
      chk_value("valid", w_valid, m_valid);
`ifdef WB_INSTRET_EN
      chk_value("instret", instret, m_retired % 16);
`else
      chk_value("instret", instret, 0);
`endif
   endtask

   task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] mem,
                        input logic mr, input logic rw, input logic [4:0] rd, input logic [2:0] f3);
      me_valid = v; me_alu_o = alu; me_mem_data = mem;
      me_mem_read = mr; me_reg_write = rw; me_rd = rd; me_funct3 = f3;
   endtask

   task automatic drive_random();
      drive(1'($urandom), $urandom, $urandom, 1'($urandom), 1'($urandom),
            ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), 3'($urandom));
   endtask

   // Directed loads: {addr, funct3, expected}
   logic [31:0] ld_addr [5] = '{32'h3, 32'h2, 32'h2, 32'h0, 32'h0};
   logic [2:0]  ld_f3   [5] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
   logic [31:0] ld_exp  [5] = '{32'hFFFF_FF80, 32'h0000_00FF, 32'hFFFF_80FF,
                                32'h0000_7F01, 32'h80FF_7F01};

   initial begin
      rst = 1'b0; stall = 1'b0; flush = 1'b0;
      drive(1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 1'b1, 5'd7, 3'd0);
      tick();
      tick();
      chk_value("reset_data", w_regs_data, 32'h0);
      #1 rst = 1'b1;

      // ALU op
      drive(1'b1, 32'h0000_1234, 32'h0, 1'b0, 1'b1, 5'd5, 3'd0);
      tick();
      chk_value("alu_data", w_regs_data, 32'h1234);
      chk_value("alu_rw", w_reg_write, 1'b1);
      chk_value("alu_rd", w_rd, 5'd5);

      for (int i = 0; i < 5; i++) begin
         #1 drive(1'b1, 32'h0000_1000 | ld_addr[i], 32'h80FF_7F01, 1'b1, 1'b1, 5'd9, ld_f3[i]);
         tick();
         chk_value("load_lane", w_regs_data, ld_exp[i]);
      end

      // Misaligned LW and LH
      #1 drive(1'b1, 32'h102, 32'h80FF_7F01, 1'b1, 1'b1, 5'd3, 3'd2);
      tick();
      chk_value("lw_mis", w_load_misalign, 1'b1);
      chk_value("lw_mis_rw", w_reg_write, 1'b0);
      #1 drive(1'b1, 32'h101, 32'h80FF_7F01, 1'b1, 1'b1, 5'd3, 3'd1);
      tick();
      chk_value("lh_mis", w_load_misalign, 1'b1);
      chk_value("lh_mis_rw", w_reg_write, 1'b0);

      // rd=0 never writes
      #1 drive(1'b1, 32'h55, 32'h0, 1'b0, 1'b1, 5'd0, 3'd0);
      tick();
      chk_value("rd0_rw", w_reg_write, 1'b0);

      // Stall three cycles with changing inputs
      #1 drive(1'b1, 32'hABCD, 32'h0, 1'b0, 1'b1, 5'd12, 3'd0);
      tick();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1 drive_random();
         tick();
         chk_value("stall_hold", w_regs_data, 32'hABCD);
      end
      // Flush beats stall
      #1 flush = 1'b1;
      tick();
      chk_value("flush_stall", w_valid, 1'b0);
      #1 flush = 1'b0;
      drive(1'b1, 32'h77, 32'h0, 1'b0, 1'b1, 5'd4, 3'd0);
      stall = 1'b0;
      tick();
      // Reset during stall
      #1 stall = 1'b1; rst = 1'b0;
      drive_random();
      tick();
      chk_value("rst_stall_valid", w_valid, 1'b0);
      chk_value("rst_stall_data", w_regs_data, 32'h0);
      #1 rst = 1'b1; stall = 1'b0;

      // Sixteen valid captures from reset wrap the 4-bit counter
      drive(1'b1, 32'h10, 32'h0, 1'b0, 1'b1, 5'd1, 3'd0);
      for (int i = 0; i < 16; i++) begin
         tick();
`ifdef WB_INSTRET_EN
         if (i == 14) chk_value("instret_15", instret, 4'd15);
`endif
      end
      chk_value("instret_wrap", instret, 4'd0);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         #1;
         drive_random();
         stall = ($urandom_range(0, 4) == 0);
         flush = ($urandom_range(0, 9) == 0);
         rst   = ($urandom_range(0, 39) != 0);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
